demultiplexer_1to2_stream: RTL and testbench

Registered 1-to-2 stream demultiplexer, the fan-out counterpart to the team's parameterizable 2-to-1 multiplexer. It accepts one N_BITS word per valid/ready handshake and routes it to output channel 0 or 1. The channel is chosen either by an explicit Selector or by an internal round-robin toggle. Each output channel has a single-entry holding register and its own valid/ready handshake. Per-channel delivered-word counters support datapath debug.

---
 rtl/demultiplexer_1to2_stream_if.sv | 59 +++++
 rtl/demultiplexer_1to2_stream.sv | 76 +++++++
 tb/tb_demultiplexer_1to2_stream.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/demultiplexer_1to2_stream_if.sv
// Handshake bundle for the 1-to-2 stream demultiplexer: one upstream port,
// two downstream channels, plus routing controls and debug counters.
interface demultiplexer_1to2_stream_if #(
    parameter int unsigned N_BITS   = 8,
    parameter int unsigned CNT_BITS = 16
);
    logic                In_Valid;
    logic                In_Ready;
    logic [N_BITS-1:0]   In_Data;
    logic                Selector;
    logic                Alternate;

    logic                Out0_Valid;
    logic                Out0_Ready;
    logic [N_BITS-1:0]   Out0_Data;
    logic                Out1_Valid;
    logic                Out1_Ready;
    logic [N_BITS-1:0]   Out1_Data;

    logic                Next_Sel;
    logic [CNT_BITS-1:0] Count_0;
    logic [CNT_BITS-1:0] Count_1;

    // Environment side: produces upstream words and consumes both channels.
    modport master (
        output In_Valid,
        output In_Data,
        output Selector,
        output Alternate,
        output Out0_Ready,
        output Out1_Ready,
        input  In_Ready,
        input  Out0_Valid,
        input  Out0_Data,
        input  Out1_Valid,
        input  Out1_Data,
        input  Next_Sel,
        input  Count_0,
        input  Count_1
    );

    // Demultiplexer side.
    modport slave (
        input  In_Valid,
        input  In_Data,
        input  Selector,
        input  Alternate,
        input  Out0_Ready,
        input  Out1_Ready,
        output In_Ready,
        output Out0_Valid,
        output Out0_Data,
        output Out1_Valid,
        output Out1_Data,
        output Next_Sel,
        output Count_0,
        output Count_1
    );
endinterface

// File: rtl/demultiplexer_1to2_stream.sv
// Registered 1-to-2 stream demultiplexer with Selector or round-robin routing,
// a single-entry holding register per channel and per-channel drain counters.
module demultiplexer_1to2_stream #(
    parameter int unsigned N_BITS   = 8,
    parameter int unsigned CNT_BITS = 16
) (
    input logic                        clk,
    input logic                        reset,
    demultiplexer_1to2_stream_if.slave bus
);
    logic                sel_eff;
    logic                in_ready;
    logic                accept;
    logic [1:0]          out_ready;
    logic [1:0]          drain;
    logic [1:0]          load;

    logic [1:0]          full_q, full_d;
    logic [N_BITS-1:0]   data_q [2];
    logic [N_BITS-1:0]   data_d [2];
    logic [CNT_BITS-1:0] cnt_q  [2];
    logic [CNT_BITS-1:0] cnt_d  [2];
    logic                next_sel_q, next_sel_d;

    assign out_ready = {bus.Out1_Ready, bus.Out0_Ready};

    // Ready looks only at the selected channel, so a blocked channel never
    // stalls traffic routed to the other one.
    always_comb begin
        sel_eff  = bus.Alternate ? next_sel_q : bus.Selector;
        drain    = full_q & out_ready;
        in_ready = ~full_q[sel_eff] | drain[sel_eff];
        accept   = bus.In_Valid & in_ready;
        load     = {accept & sel_eff, accept & ~sel_eff};
    end

    always_comb begin
        next_sel_d = next_sel_q;
        if (accept && bus.Alternate) begin
            next_sel_d = ~next_sel_q;
        end
        for (int i = 0; i < 2; i++) begin
            // Load wins over drain, so a full channel streams without a bubble.
            full_d[i] = load[i] | (full_q[i] & ~drain[i]);
            data_d[i] = load[i] ? bus.In_Data : data_q[i];
            cnt_d[i]  = drain[i] ? cnt_q[i] + CNT_BITS'(1) : cnt_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q     <= 2'b00;
            next_sel_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            full_q     <= full_d;
            next_sel_q <= next_sel_d;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= data_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    assign bus.In_Ready   = in_ready;
    assign bus.Out0_Valid = full_q[0];
    assign bus.Out0_Data  = data_q[0];
    assign bus.Out1_Valid = full_q[1];
    assign bus.Out1_Data  = data_q[1];
    assign bus.Next_Sel   = next_sel_q;
    assign bus.Count_0    = cnt_q[0];
    assign bus.Count_1    = cnt_q[1];
endmodule

// File: tb/tb_demultiplexer_1to2_stream.sv
// Scoreboard bench for demultiplexer_1to2_stream: per-channel expected-word
// queues filled on accept, drained and compared by a separate monitor.
module tb_demultiplexer_1to2_stream;
    localparam int CW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    demultiplexer_1to2_stream_if #(.N_BITS(8), .CNT_BITS(CW)) bus ();

    demultiplexer_1to2_stream #(
        .N_BITS   (8),
        .CNT_BITS (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a channel is "full" exactly when its queue holds a word.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] last_d [2];
    int         cnt    [2];
    logic       m_ns;
    bit         armed  = 0;
    bit         stim_done = 0;

    // Decision taken before an edge, applied to the model just after it.
    bit         p_acc = 0;
    bit         p_sel = 0;
    bit         p_alt = 0;
    bit         p_rst = 0;
    logic [7:0] p_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic commit();
        if (p_rst) begin
            q0.delete();
            q1.delete();
            last_d[0] = 8'h00;
            last_d[1] = 8'h00;
            cnt[0]    = 0;
            cnt[1]    = 0;
            m_ns      = 1'b0;
            armed     = 1;
        end else if (p_acc) begin
            if (p_sel) begin
                q1.push_back(p_data);
                last_d[1] = p_data;
            end else begin
                q0.push_back(p_data);
                last_d[0] = p_data;
            end
            if (p_alt) m_ns = ~m_ns;
        end
        p_acc = 0;
        p_rst = 0;
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic s, input logic a,
                        input logic r0, input logic r1, input logic rst);
        logic sel;
        logic rdy;
        @(posedge clk);
        #1;
        commit();
        reset          = rst;
        bus.In_Valid   = v;
        bus.In_Data    = d;
        bus.Selector   = s;
        bus.Alternate  = a;
        bus.Out0_Ready = r0;
        bus.Out1_Ready = r1;
        #2;
        p_rst = rst;
        if (armed) begin
            sel = a ? m_ns : s;
            rdy = sel ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0);
            chk("in_ready", {31'd0, bus.In_Ready}, {31'd0, rdy});
            p_acc  = v && rdy;
            p_sel  = sel;
            p_alt  = a;
            p_data = d;
        end
    endtask

    task automatic monitor();
        logic [7:0] exp;
        while (!stim_done) begin
            @(negedge clk);
            if (armed) begin
                chk("next_sel", {31'd0, bus.Next_Sel}, {31'd0, m_ns});
                chk("out0_valid", {31'd0, bus.Out0_Valid}, (q0.size() != 0) ? 1 : 0);
                chk("out1_valid", {31'd0, bus.Out1_Valid}, (q1.size() != 0) ? 1 : 0);
                chk("out0_data", {24'd0, bus.Out0_Data}, {24'd0, last_d[0]});
                chk("out1_data", {24'd0, bus.Out1_Data}, {24'd0, last_d[1]});
                chk("count0", {28'd0, bus.Count_0}, cnt[0]);
                chk("count1", {28'd0, bus.Count_1}, cnt[1]);
                if (bus.Out0_Valid === 1'b1 && bus.Out0_Ready === 1'b1) begin
                    if (q0.size() == 0) begin
                        chk("drain0_unexpected", 1, 0);
                    end else begin
                        exp = q0.pop_front();
                        chk("drain0_word", {24'd0, bus.Out0_Data}, {24'd0, exp});
                    end
                    cnt[0] = (cnt[0] + 1) % (1 << CW);
                end
                if (bus.Out1_Valid === 1'b1 && bus.Out1_Ready === 1'b1) begin
                    if (q1.size() == 0) begin
                        chk("drain1_unexpected", 1, 0);
                    end else begin
                        exp = q1.pop_front();
                        chk("drain1_word", {24'd0, bus.Out1_Data}, {24'd0, exp});
                    end
                    cnt[1] = (cnt[1] + 1) % (1 << CW);
                end
            end
        end
    endtask

    task automatic stimulus();
        // Reset
        step(0, 8'h00, 0, 0, 1, 1, 1);
        step(0, 8'h00, 0, 0, 1, 1, 1);
        step(0, 8'h00, 0, 0, 0, 0, 0);
        chk("rst_in_ready", {31'd0, bus.In_Ready}, 1);
        // Selector routing to channel 1
        step(1, 8'hA5, 1, 0, 0, 1, 0);
        step(0, 8'h00, 1, 0, 0, 1, 0);
        step(0, 8'h00, 1, 0, 0, 1, 0);
        chk("a5_count1", {28'd0, bus.Count_1}, 1);
        chk("a5_count0", {28'd0, bus.Count_0}, 0);
        // Round-robin stream, both consumers ready
        for (int i = 1; i <= 6; i++) step(1, 8'(i), 0, 1, 1, 1, 0);
        step(0, 8'h00, 0, 1, 1, 1, 0);
        step(0, 8'h00, 0, 1, 1, 1, 0);
        chk("rr_next_sel", {31'd0, bus.Next_Sel}, 0);
        chk("rr_count0", {28'd0, bus.Count_0}, 3);
        chk("rr_count1", {28'd0, bus.Count_1}, 4);
        // Backpressure on channel 0, then drain-and-load in one cycle
        step(1, 8'h11, 0, 0, 0, 1, 0);
        step(1, 8'h22, 0, 0, 0, 1, 0);
        step(1, 8'h22, 0, 0, 0, 1, 0);
        chk("bp_in_ready", {31'd0, bus.In_Ready}, 0);
        step(1, 8'h22, 0, 0, 1, 1, 0);
        // Channel 0 blocked, channel 1 still accepts
        step(1, 8'h33, 1, 0, 0, 1, 0);
        step(0, 8'h00, 1, 0, 0, 1, 0);
        chk("blk_ch0_data", {24'd0, bus.Out0_Data}, 32'h22);
        step(0, 8'h00, 0, 0, 1, 1, 0);
        step(0, 8'h00, 0, 0, 1, 1, 0);
        // Counter wrap on channel 0
        for (int i = 0; i < 17; i++) step(1, 8'(8'h80 + i), 0, 0, 1, 0, 0);
        step(0, 8'h00, 0, 0, 1, 1, 0);
        step(0, 8'h00, 0, 0, 1, 1, 0);
        // Reset with both channels full and toggle at 1
        step(0, 8'h00, 0, 0, 1, 1, 1);
        step(1, 8'h40, 0, 1, 0, 0, 0);
        step(1, 8'h41, 1, 0, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0, 0, 0);
        chk("pre_rst_ns", {31'd0, bus.Next_Sel}, 1);
        step(0, 8'h00, 0, 0, 0, 0, 1);
        step(0, 8'h00, 0, 1, 0, 0, 0);
        chk("mid_rst_v0", {31'd0, bus.Out0_Valid}, 0);
        chk("mid_rst_v1", {31'd0, bus.Out1_Valid}, 0);
        chk("mid_rst_d1", {24'd0, bus.Out1_Data}, 0);
        chk("mid_rst_ns", {31'd0, bus.Next_Sel}, 0);
        step(1, 8'h55, 1, 1, 1, 1, 0);
        step(0, 8'h00, 0, 0, 0, 0, 0);
        chk("post_rst_ch0", {24'd0, bus.Out0_Data}, 32'h55);
        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 199) == 0);
        end
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0, 1, 1, 0);
        stim_done = 1;
    endtask

    initial begin
        bus.In_Valid   = 1'b0;
        bus.In_Data    = 8'h00;
        bus.Selector   = 1'b0;
        bus.Alternate  = 1'b0;
        bus.Out0_Ready = 1'b0;
        bus.Out1_Ready = 1'b0;
        m_ns           = 1'b0;
        last_d[0]      = 8'h00;
        last_d[1]      = 8'h00;
        cnt[0]         = 0;
        cnt[1]         = 0;
        fork
            monitor();
            stimulus();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
